aia_imsic_intp_files: RTL

- Parametrised AIA interrupt-file block: one M-level, one S-level and NrVSIntpFiles guest (VS) interrupt files.
- Files take MSI writes from the bus-side MSI decoder and serve CSR accesses from the CSR file (eip/eie/eithreshold/eidelivery/topei).
- Per file it keeps pending and enable arrays, computes a registered top identity, and drives per-file interrupt lines to the CSR/interrupt logic.
- Generalises the fixed M/S/one-VS, 30-source AIA configuration to any file count and source count.

---
 rtl/aia_imsic_intp_files.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/aia_imsic_intp_files.sv
// AIA IMSIC interrupt files: M, S and NrVSIntpFiles guest files with MSI set, CSR access and topei.
// Optional AIA_IMSIC_MSI_FIFO_EN inserts a 4-entry MSI FIFO ahead of the pending arrays.
module aia_imsic_intp_files #(
  parameter int NrVSIntpFiles = 1,
  parameter int NrSources     = 32,
  parameter int NrSourcesW    = $clog2(NrSources),
  parameter int NrFilesW      = $clog2(2 + NrVSIntpFiles)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       msi_valid_i,
  output logic                       msi_ready_o,
  input  logic [NrFilesW-1:0]        msi_file_i,
  input  logic [NrSourcesW-1:0]      msi_id_i,
  input  logic                       csr_valid_i,
  output logic                       csr_ready_o,
  input  logic [NrFilesW-1:0]        csr_file_i,
  input  logic [2:0]                 csr_op_i,
  input  logic [NrSourcesW-1:0]      csr_id_i,
  output logic                       csr_rvalid_o,
  output logic [31:0]                csr_rdata_o,
  output logic [NrVSIntpFiles+1:0]   irq_o,
  output logic [7:0]                 drop_cnt_o
);
  localparam int NrFiles = 2 + NrVSIntpFiles;

  localparam logic [2:0] OpReadTopei  = 3'd0;
  localparam logic [2:0] OpClaimTopei = 3'd1;
  localparam logic [2:0] OpSetEie     = 3'd2;
  localparam logic [2:0] OpClrEie     = 3'd3;
  localparam logic [2:0] OpSetEip     = 3'd4;
  localparam logic [2:0] OpClrEip     = 3'd5;
  localparam logic [2:0] OpWrThresh   = 3'd6;
  localparam logic [2:0] OpWrDelivery = 3'd7;

  logic [NrSources-1:0]  eip_reg    [NrFiles];
  logic [NrSources-1:0]  eip_next   [NrFiles];
  logic [NrSources-1:0]  eie_reg    [NrFiles];
  logic [NrSources-1:0]  eie_next   [NrFiles];
  logic [NrSourcesW-1:0] thresh_reg [NrFiles];
  logic [NrSourcesW-1:0] thresh_next[NrFiles];
  logic [NrSourcesW-1:0] top_reg    [NrFiles];
  logic [NrSourcesW-1:0] top_next   [NrFiles];
  logic [NrFiles-1:0]    delivery_reg, delivery_next;
  logic [NrFiles-1:0]    irq_reg, irq_next;

  logic        stall_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic [7:0]  drop_reg;

  logic                  csr_fire, csr_file_ok, csr_id_ok;
  logic                  msi_fire, msi_in_ok;
  logic [NrSourcesW-1:0] csr_top;
  logic [10:0]           top_id11;
  logic                  apply_valid;
  logic [NrFilesW-1:0]   apply_file;
  logic [NrSourcesW-1:0] apply_id;

  assign csr_ready_o  = !stall_reg;
  assign csr_fire     = csr_valid_i && csr_ready_o;
  assign csr_file_ok  = int'(csr_file_i) < NrFiles;
  assign csr_id_ok    = (csr_id_i != '0) && (int'(csr_id_i) < NrSources);
  assign msi_fire     = msi_valid_i && msi_ready_o;
  assign msi_in_ok    = (msi_id_i != '0) && (int'(msi_id_i) < NrSources) &&
                        (int'(msi_file_i) < NrFiles);

  assign csr_rvalid_o = rvalid_reg;
  assign csr_rdata_o  = rdata_reg;
  assign irq_o        = irq_reg;
  assign drop_cnt_o   = drop_reg;

`ifdef AIA_IMSIC_MSI_FIFO_EN
  logic [NrFilesW-1:0]   fifo_file_reg [4];
  logic [NrSourcesW-1:0] fifo_id_reg   [4];
  logic [1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [2:0]            count_reg;
  logic                  fifo_push, fifo_pop, head_clash;
  logic [NrFilesW-1:0]   head_file;
  logic [NrSourcesW-1:0] head_id;

  assign msi_ready_o = (count_reg != 3'd4);
  assign fifo_push   = msi_fire && msi_in_ok;
  assign head_file   = fifo_file_reg[rd_ptr_reg];
  assign head_id     = fifo_id_reg[rd_ptr_reg];
  // Hold the head back one cycle when a clear hits the same bit, so the set lands after it.
  assign head_clash  = csr_fire && (csr_file_i == head_file) &&
                       (((csr_op_i == OpClrEip) && (csr_id_i == head_id)) ||
                        ((csr_op_i == OpClaimTopei) && (csr_top == head_id)));
  assign fifo_pop    = (count_reg != 3'd0) && !head_clash;
  assign apply_valid = fifo_pop;
  assign apply_file  = head_file;
  assign apply_id    = head_id;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_file_reg[wr_ptr_reg] <= msi_file_i;
        fifo_id_reg[wr_ptr_reg]   <= msi_id_i;
        wr_ptr_reg                <= wr_ptr_reg + 2'd1;
      end
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + 3'(fifo_push) - 3'(fifo_pop);
    end
  end
`else
  assign msi_ready_o = 1'b1;
  assign apply_valid = msi_fire && msi_in_ok;
  assign apply_file  = msi_file_i;
  assign apply_id    = msi_id_i;
`endif

  always_comb begin
    csr_top = '0;
    for (int f = 0; f < NrFiles; f++) begin
      if (f == int'(csr_file_i)) csr_top = top_reg[f];
    end
  end

  assign top_id11 = 11'(csr_top);

  always_comb begin
    rdata_next = '0;
    if (csr_file_ok && ((csr_op_i == OpReadTopei) || (csr_op_i == OpClaimTopei)))
      rdata_next = {5'b0, top_id11, 5'b0, top_id11};
  end

  // Clears are applied before sets so a same-cycle MSI always survives.
  always_comb begin
    for (int f = 0; f < NrFiles; f++) begin
      eip_next[f]      = eip_reg[f];
      eie_next[f]      = eie_reg[f];
      thresh_next[f]   = thresh_reg[f];
      delivery_next[f] = delivery_reg[f];
      if (csr_fire && (f == int'(csr_file_i))) begin
        case (csr_op_i)
          OpSetEie:     if (csr_id_ok) eie_next[f][csr_id_i] = 1'b1;
          OpClrEie:     if (csr_id_ok) eie_next[f][csr_id_i] = 1'b0;
          OpClrEip:     if (csr_id_ok) eip_next[f][csr_id_i] = 1'b0;
          OpClaimTopei: if (top_reg[f] != '0) eip_next[f][top_reg[f]] = 1'b0;
          OpWrThresh:   thresh_next[f] = csr_id_i;
          OpWrDelivery: delivery_next[f] = csr_id_i[0];
          default: ;
        endcase
        if ((csr_op_i == OpSetEip) && csr_id_ok) eip_next[f][csr_id_i] = 1'b1;
      end
      if (apply_valid && (f == int'(apply_file))) eip_next[f][apply_id] = 1'b1;
    end
  end

  // Descending scan leaves the lowest qualifying identity in top_next.
  always_comb begin
    for (int f = 0; f < NrFiles; f++) begin
      top_next[f] = '0;
      for (int i = NrSources - 1; i >= 1; i--) begin
        if (eip_reg[f][i] && eie_reg[f][i] &&
            ((thresh_reg[f] == '0) || (i < int'(thresh_reg[f]))))
          top_next[f] = NrSourcesW'(i);
      end
      irq_next[f] = delivery_reg[f] && (top_next[f] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int f = 0; f < NrFiles; f++) begin
        eip_reg[f]    <= '0;
        eie_reg[f]    <= '0;
        thresh_reg[f] <= '0;
        top_reg[f]    <= '0;
      end
      delivery_reg <= '0;
      irq_reg      <= '0;
      stall_reg    <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      drop_reg     <= '0;
    end else begin
      for (int f = 0; f < NrFiles; f++) begin
        eip_reg[f]    <= eip_next[f];
        eie_reg[f]    <= eie_next[f];
        thresh_reg[f] <= thresh_next[f];
        top_reg[f]    <= top_next[f];
      end
      delivery_reg <= delivery_next;
      irq_reg      <= irq_next;
      stall_reg    <= csr_fire && (csr_op_i == OpClaimTopei);
      rvalid_reg   <= csr_fire;
      if (csr_fire) rdata_reg <= rdata_next;
      if (msi_fire && !msi_in_ok && (drop_reg != 8'hFF)) drop_reg <= drop_reg + 8'd1;
    end
  end
endmodule
